// File: rtl/cb_douta_router.sv
// Routes one L-lane cache-bank read word to the A, B or M operand port.
// The select is delayed by RD_LAT cycles to meet the returning read data, then mapped and registered.
module cb_douta_router #(
   parameter int unsigned X      = 4,
   parameter int unsigned Y      = 4,
   parameter int unsigned L      = 4,
   parameter int unsigned RSA_DW = 16,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned NEW_W  = 2,
   parameter int unsigned LK_W   = 1
) (
   input  logic                  clk,
   input  logic                  sys_rst_n,
   input  logic                  sel_vld,
   input  logic [3:0]            CB_douta_sel,
   input  logic [LK_W-1:0]       l_k,
   input  logic [L*RSA_DW-1:0]   CB_douta,
   input  logic                  err_clr,
   output logic [X*RSA_DW-1:0]   A_CB_douta,
   output logic [Y*RSA_DW-1:0]   B_CB_douta,
   output logic [X*RSA_DW-1:0]   M_CB_douta,
   output logic                  A_vld,
   output logic                  B_vld,
   output logic                  M_vld,
   output logic                  err_sticky
);

   localparam int unsigned NWIN = L / NEW_W;

   localparam logic [1:0] DIR_POS  = 2'b01;
   localparam logic [1:0] DIR_NEG  = 2'b10;
   localparam logic [1:0] DIR_NEW  = 2'b11;
   localparam logic [1:0] DEST_NONE = 2'b00;
   localparam logic [1:0] DEST_A    = 2'b01;
   localparam logic [1:0] DEST_B    = 2'b10;
   localparam logic [1:0] DEST_M    = 2'b11;

   logic                d_vld;
   logic [3:0]          d_sel;
   logic [LK_W-1:0]     d_lk;

   // Select delay line: aligns the select with the read data RD_LAT cycles later
   generate
      if (RD_LAT == 0) begin : g_no_dly
         assign d_vld = sel_vld;
         assign d_sel = CB_douta_sel;
         assign d_lk  = l_k;
      end else begin : g_dly
         logic            vld_q [RD_LAT];
         logic [3:0]      sel_q [RD_LAT];
         logic [LK_W-1:0] lk_q  [RD_LAT];

         always_ff @(posedge clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
               for (int unsigned i = 0; i < RD_LAT; i++) begin
                  vld_q[i] <= 1'b0;
                  sel_q[i] <= 4'd0;
                  lk_q[i]  <= '0;
               end
            end else begin
               vld_q[0] <= sel_vld;
               sel_q[0] <= CB_douta_sel;
               lk_q[0]  <= l_k;
               for (int unsigned i = 1; i < RD_LAT; i++) begin
                  vld_q[i] <= vld_q[i-1];
                  sel_q[i] <= sel_q[i-1];
                  lk_q[i]  <= lk_q[i-1];
               end
            end
         end

         assign d_vld = vld_q[RD_LAT-1];
         assign d_sel = sel_q[RD_LAT-1];
         assign d_lk  = lk_q[RD_LAT-1];
      end
   endgenerate

   logic [1:0]          dest;
   logic [1:0]          dir;
   logic                route;
   logic                illegal;
   logic [RSA_DW-1:0]   lane [L];
   logic [RSA_DW-1:0]   m    [L];
   int unsigned         win;

   assign dest    = d_sel[3:2];
   assign dir     = d_sel[1:0];
   assign route   = d_vld && (dest != DEST_NONE);
   assign illegal = d_vld && (dest == DEST_NONE) && (dir != 2'b00);

   // Lane mapping; NEW picks window (l_k + 1) mod NWIN
   always_comb begin
      win = 0;
      for (int unsigned i = 0; i < L; i++) begin
         lane[i] = CB_douta[i*RSA_DW +: RSA_DW];
         m[i]    = '0;
      end
      win = (32'(d_lk) + 32'd1) % NWIN;
      case (dir)
         DIR_POS: for (int unsigned j = 0; j < L; j++) m[j] = lane[j];
         DIR_NEG: for (int unsigned j = 0; j < L; j++) m[j] = lane[L-1-j];
         DIR_NEW: begin
            for (int unsigned j = 0; j < NEW_W; j++) begin
               for (int unsigned i = 0; i < L; i++) begin
                  if (i == win * NEW_W + j) m[j] = lane[i];
               end
            end
         end
         default: ;
      endcase
   end

   logic [X*RSA_DW-1:0] map_x;
   logic [Y*RSA_DW-1:0] map_y;

   // Fit the mapped word to each port width: missing lanes read 0, extra lanes drop
   generate
      for (genvar j = 0; j < X; j++) begin : g_map_x
         if (j < L) begin : g_lane
            assign map_x[j*RSA_DW +: RSA_DW] = m[j];
         end else begin : g_zero
            assign map_x[j*RSA_DW +: RSA_DW] = '0;
         end
      end
      for (genvar j = 0; j < Y; j++) begin : g_map_y
         if (j < L) begin : g_lane
            assign map_y[j*RSA_DW +: RSA_DW] = m[j];
         end else begin : g_zero
            assign map_y[j*RSA_DW +: RSA_DW] = '0;
         end
      end
   endgenerate

   // Output registers; error set wins over clear
   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         A_CB_douta <= '0;
         B_CB_douta <= '0;
         M_CB_douta <= '0;
         A_vld      <= 1'b0;
         B_vld      <= 1'b0;
         M_vld      <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         A_vld      <= route && (dest == DEST_A);
         B_vld      <= route && (dest == DEST_B);
         M_vld      <= route && (dest == DEST_M);
         A_CB_douta <= (route && (dest == DEST_A)) ? map_x : '0;
         B_CB_douta <= (route && (dest == DEST_B)) ? map_y : '0;
         M_CB_douta <= (route && (dest == DEST_M)) ? map_x : '0;
         if (illegal)
            err_sticky <= 1'b1;
         else if (err_clr)
            err_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cb_douta_router.sv
// Directed self-checking bench for cb_douta_router (RSA_DW=16, L=X=Y=4, RD_LAT=1).
module tb_cb_douta_router;

   localparam int unsigned X      = 4;
   localparam int unsigned Y      = 4;
   localparam int unsigned L      = 4;
   localparam int unsigned RSA_DW = 16;
   localparam int unsigned RD_LAT = 1;
   localparam int unsigned NEW_W  = 2;
   localparam int unsigned LK_W   = 1;

   localparam logic [63:0] DATA = 64'h0004_0003_0002_0001;

   logic                clk;
   logic                sys_rst_n;
   logic                sel_vld;
   logic [3:0]          CB_douta_sel;
   logic [LK_W-1:0]     l_k;
   logic [L*RSA_DW-1:0] CB_douta;
   logic                err_clr;
   logic [X*RSA_DW-1:0] A_CB_douta;
   logic [Y*RSA_DW-1:0] B_CB_douta;
   logic [X*RSA_DW-1:0] M_CB_douta;
   logic                A_vld;
   logic                B_vld;
   logic                M_vld;
   logic                err_sticky;

   int n_checks = 0;
   int n_fail   = 0;

   cb_douta_router #(
      .X(X), .Y(Y), .L(L), .RSA_DW(RSA_DW), .RD_LAT(RD_LAT), .NEW_W(NEW_W), .LK_W(LK_W)
   ) dut (
      .clk          (clk),
      .sys_rst_n    (sys_rst_n),
      .sel_vld      (sel_vld),
      .CB_douta_sel (CB_douta_sel),
      .l_k          (l_k),
      .CB_douta     (CB_douta),
      .err_clr      (err_clr),
      .A_CB_douta   (A_CB_douta),
      .B_CB_douta   (B_CB_douta),
      .M_CB_douta   (M_CB_douta),
      .A_vld        (A_vld),
      .B_vld        (B_vld),
      .M_vld        (M_vld),
      .err_sticky   (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   // Drive one cycle of inputs, then advance past the next rising edge
   task automatic drive(input logic vld, input logic [3:0] sel, input logic [LK_W-1:0] lk,
                        input logic clr);
      sel_vld      = vld;
      CB_douta_sel = sel;
      l_k          = lk;
      err_clr      = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic check_ports(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] m, input logic [2:0] vld);
      check({tag, "_A"}, A_CB_douta, a);
      check({tag, "_B"}, B_CB_douta, b);
      check({tag, "_M"}, M_CB_douta, m);
      check({tag, "_vld"}, {61'd0, A_vld, B_vld, M_vld}, {61'd0, vld});
   endtask

   initial begin
      sys_rst_n    = 1'b0;
      sel_vld      = 1'b0;
      CB_douta_sel = 4'd0;
      l_k          = '0;
      err_clr      = 1'b0;
      CB_douta     = DATA;

      // Random inputs while held in reset
      for (int i = 0; i < 5; i++) begin
         sel_vld      = 1'($urandom);
         CB_douta_sel = 4'($urandom);
         l_k          = LK_W'($urandom);
         err_clr      = 1'($urandom);
         CB_douta     = {$urandom, $urandom};
         @(posedge clk);
         #1;
         check_ports("rst_hold", 64'd0, 64'd0, 64'd0, 3'b000);
         check("rst_hold_err", {63'd0, err_sticky}, 64'd0);
      end
      CB_douta = DATA;
      drive(1'b0, 4'd0, '0, 1'b0);
      sys_rst_n = 1'b1;
      drive(1'b0, 4'd0, '0, 1'b0);

      // Select in flight, then async reset mid-pipeline
      drive(1'b1, 4'b0101, '0, 1'b0);
      sel_vld   = 1'b0;
      sys_rst_n = 1'b0;
      #2;
      sys_rst_n = 1'b1;
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("rst_flight1", 64'd0, 64'd0, 64'd0, 3'b000);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("rst_flight2", 64'd0, 64'd0, 64'd0, 3'b000);

      // POS to A
      drive(1'b1, 4'b0101, '0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("pos_a", 64'h0004_0003_0002_0001, 64'd0, 64'd0, 3'b100);

      // NEG to M
      drive(1'b1, 4'b1110, '0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("neg_m", 64'd0, 64'd0, 64'h0001_0002_0003_0004, 3'b001);

      // NEW to B, both windows
      drive(1'b1, 4'b1011, 1'b1, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("new_b_lk1", 64'd0, 64'h0000_0000_0002_0001, 64'd0, 3'b010);
      drive(1'b1, 4'b1011, 1'b0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("new_b_lk0", 64'd0, 64'h0000_0000_0004_0003, 64'd0, 3'b010);

      // IDLE dir with a destination: valid with zero data
      drive(1'b1, 4'b0100, '0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("idle_a", 64'd0, 64'd0, 64'd0, 3'b100);

      // sel_vld low: nothing routed regardless of select
      drive(1'b0, 4'b0101, '0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("novld", 64'd0, 64'd0, 64'd0, 3'b000);

      // Back-to-back A POS, B NEG, M NEW
      drive(1'b1, 4'b0101, '0, 1'b0);
      drive(1'b1, 4'b1010, '0, 1'b0);
      check_ports("b2b_a", 64'h0004_0003_0002_0001, 64'd0, 64'd0, 3'b100);
      drive(1'b1, 4'b1111, 1'b1, 1'b0);
      check_ports("b2b_b", 64'd0, 64'h0001_0002_0003_0004, 64'd0, 3'b010);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("b2b_m", 64'd0, 64'd0, 64'h0000_0000_0002_0001, 3'b001);
      drive(1'b0, 4'd0, '0, 1'b0);
      check_ports("b2b_end", 64'd0, 64'd0, 64'd0, 3'b000);

      // Illegal select sets the sticky error
      check("err_pre", {63'd0, err_sticky}, 64'd0);
      drive(1'b1, 4'b0001, '0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0);
      check("err_set", {63'd0, err_sticky}, 64'd1);
      check_ports("err_out", 64'd0, 64'd0, 64'd0, 3'b000);
      drive(1'b0, 4'd0, '0, 1'b0);
      check("err_hold", {63'd0, err_sticky}, 64'd1);
      drive(1'b0, 4'd0, '0, 1'b1);
      check("err_clr", {63'd0, err_sticky}, 64'd0);

      // Second error and clear on the same edge: set wins
      drive(1'b1, 4'b0010, '0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b0);
      check("err_set2", {63'd0, err_sticky}, 64'd1);
      drive(1'b1, 4'b0011, '0, 1'b0);
      drive(1'b0, 4'd0, '0, 1'b1);
      check("err_set_wins", {63'd0, err_sticky}, 64'd1);
      drive(1'b0, 4'd0, '0, 1'b1);
      check("err_clr2", {63'd0, err_sticky}, 64'd0);
      drive(1'b0, 4'd0, '0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
